// File: rtl/gsm_pkt_arbiter_pkg.sv
// Shared definitions for the GSM egress packet arbiter: FSM encoding and index-width helper.
package gsm_pkt_arbiter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_LOCK = ST_LOCK
    } arb_state_e;

    // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
    function automatic int unsigned clogb(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/gsm_pkt_arbiter_if.sv
// Queue-side bundle of the egress arbiter; master drives requests, slave is the arbiter.
interface gsm_pkt_arbiter_if
    import gsm_pkt_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORT = 8
);
    localparam int unsigned IW = clogb(NUM_PORT);

    logic [NUM_PORT-1:0] req;
    logic [NUM_PORT-1:0] eop;
    logic                stall;
    logic [NUM_PORT-1:0] grant;
    logic [IW-1:0]       owner_id;
    logic                busy;
    logic                pkt_done;
    logic                err_len;
    logic                wd_abort;

    modport master (
        output req, eop, stall,
        input  grant, owner_id, busy, pkt_done, err_len, wd_abort
    );

    modport slave (
        input  req, eop, stall,
        output grant, owner_id, busy, pkt_done, err_len, wd_abort
    );

endinterface

// File: rtl/gsm_rr_pick.sv
// Rotating-priority search: first set req bit at or after ptr, wrapping. Pure combinational.
module gsm_rr_pick #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o,
    output logic          any_o
);
    localparam logic [IW:0] N_EXT = (IW+1)'(N);

    logic [IW:0]   pos;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        pos      = '0;
        idx      = '0;
        found    = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= N_EXT) pos = pos - N_EXT;
            idx = pos[IW-1:0];
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                onehot_o[idx] = 1'b1;
                index_o       = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/gsm_pkt_arbiter.sv
// Packet-aware round-robin egress arbiter: zero-cycle grant, status outputs lag one cycle, stall freezes all state.
// Optional GSM_ARB_WATCHDOG_EN releases a lock whose owner stays empty for WD_LIMIT unstalled cycles.
module gsm_pkt_arbiter
    import gsm_pkt_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORT  = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned WD_LIMIT  = 255
) (
    input  logic              clk,
    input  logic              clr,
    gsm_pkt_arbiter_if.slave  arb
);
    localparam int unsigned   IW        = clogb(NUM_PORT);
    localparam int unsigned   BW        = clogb(MAX_BEATS + 1);
    localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_BEATS);
    localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORT - 1);

    if (NUM_PORT < 2 || MAX_BEATS < 2 || WD_LIMIT < 1) begin : g_param_chk
        $error("gsm_pkt_arbiter: NUM_PORT/MAX_BEATS must be >= 2, WD_LIMIT >= 1");
    end

    arb_state_e    state_q;
    logic [IW-1:0] ptr_q, owner_q, owner_id_q;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          busy_q, pkt_done_q, err_len_q;

    logic [NUM_PORT-1:0] win_oh, grant_d;
    logic [IW-1:0]       win_idx, win_next_d, owner_next_d;
    logic                win_any, beat;

    gsm_rr_pick #(.N(NUM_PORT), .IW(IW)) u_pick (
        .req_i    (arb.req),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .index_o  (win_idx),
        .any_o    (win_any)
    );

    always_comb begin
        grant_d = '0;
        if (!clr) begin
            if (state_q == S_IDLE) begin
                if (win_any && !arb.stall) grant_d = win_oh;
            end else if (arb.req[owner_q] && !arb.stall) begin
                grant_d[owner_q] = 1'b1;
            end
        end
    end

    assign beat         = |grant_d;
    assign beat_cnt_d   = beat_cnt_q + BW'(1);
    assign win_next_d   = (win_idx == LAST_PORT) ? '0 : win_idx + IW'(1);
    assign owner_next_d = (owner_q == LAST_PORT) ? '0 : owner_q + IW'(1);

`ifdef GSM_ARB_WATCHDOG_EN
    localparam int unsigned   WW     = clogb(WD_LIMIT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WD_LIMIT);
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_abort_q;
    assign wd_cnt_d = wd_cnt_q + WW'(1);
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            owner_id_q <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            err_len_q  <= 1'b0;
`ifdef GSM_ARB_WATCHDOG_EN
            wd_cnt_q   <= '0;
            wd_abort_q <= 1'b0;
`endif
        end else begin
            pkt_done_q <= 1'b0;
`ifdef GSM_ARB_WATCHDOG_EN
            wd_abort_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
`ifdef GSM_ARB_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                    if (beat) begin
                        owner_id_q <= win_idx;
                        if (arb.eop[win_idx]) begin
                            ptr_q      <= win_next_d;
                            pkt_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_LOCK;
                            busy_q     <= 1'b1;
                            owner_q    <= win_idx;
                            beat_cnt_q <= BW'(1);
                        end
                    end
                end
                S_LOCK: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_d;
`ifdef GSM_ARB_WATCHDOG_EN
                        wd_cnt_q   <= '0;
`endif
                        // eop wins over the length limit when both land on the same beat
                        if (arb.eop[owner_q]) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            ptr_q      <= owner_next_d;
                            pkt_done_q <= 1'b1;
                        end else if (beat_cnt_d == BEAT_MAX) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            ptr_q      <= owner_next_d;
                            err_len_q  <= 1'b1;
                        end
                    end
`ifdef GSM_ARB_WATCHDOG_EN
                    else if (!arb.stall && !arb.req[owner_q]) begin
                        if (wd_cnt_d == WD_MAX) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            ptr_q      <= owner_next_d;
                            wd_abort_q <= 1'b1;
                            wd_cnt_q   <= '0;
                        end else begin
                            wd_cnt_q   <= wd_cnt_d;
                        end
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb.grant    = grant_d;
    assign arb.owner_id = owner_id_q;
    assign arb.busy     = busy_q;
    assign arb.pkt_done = pkt_done_q;
    assign arb.err_len  = err_len_q;
`ifdef GSM_ARB_WATCHDOG_EN
    assign arb.wd_abort = wd_abort_q;
`else
    assign arb.wd_abort = 1'b0;
`endif

endmodule

// File: tb/tb_gsm_pkt_arbiter.sv
// Scoreboard bench for gsm_pkt_arbiter (default build, NUM_PORT=8, MAX_BEATS=16).
module tb_gsm_pkt_arbiter;
    import gsm_pkt_arbiter_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    gsm_pkt_arbiter_if #(.NUM_PORT(8)) arb ();

    gsm_pkt_arbiter #(.NUM_PORT(8), .MAX_BEATS(16), .WD_LIMIT(255)) dut (
        .clk (clk),
        .clr (clr),
        .arb (arb)
    );

    typedef struct packed {
        logic [7:0] g;
        logic       busy;
        logic       done;
        logic [2:0] oid;
        logic       err;
        logic       chk_reg;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    // One cycle of stimulus plus the outputs expected during that same cycle.
    task automatic cyc(input logic c, input logic [7:0] r, input logic [7:0] e, input logic s,
                       input logic [7:0] g, input logic b, input logic d, input logic [2:0] o,
                       input logic er, input logic ck = 1'b1);
        @(posedge clk);
        #1;
        clr       = c;
        arb.req   = r;
        arb.eop   = e;
        arb.stall = s;
        sb_q.push_back('{g: g, busy: b, done: d, oid: o, err: er, chk_reg: ck});
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            chk("grant", 32'(arb.grant), 32'(cur.g));
            if (cur.chk_reg) begin
                chk("busy",     32'(arb.busy),     32'(cur.busy));
                chk("pkt_done", 32'(arb.pkt_done), 32'(cur.done));
                chk("owner_id", 32'(arb.owner_id), 32'(cur.oid));
                chk("err_len",  32'(arb.err_len),  32'(cur.err));
                chk("wd_abort", 32'(arb.wd_abort), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        arb.req   = '0;
        arb.eop   = '0;
        arb.stall = 1'b0;

        // reset: grant held off while clr is high, even with every queue requesting
        cyc(1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 0, 0, 1'b0);
        cyc(1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 0, 0);

        // single-beat packets from queues 0 and 2 rotate on consecutive cycles
        cyc(0, 8'h05, 8'hFF, 0, 8'h01, 0, 0, 0, 0);
        cyc(0, 8'h05, 8'hFF, 0, 8'h04, 0, 1, 0, 0);
        cyc(0, 8'h05, 8'hFF, 0, 8'h01, 0, 1, 2, 0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);

        // queue 3 four-beat packet holds off queue 5, which follows with no bubble
        cyc(0, 8'h28, 8'h20, 0, 8'h08, 0, 0, 0, 0);
        cyc(0, 8'h28, 8'h20, 0, 8'h08, 1, 0, 3, 0);
        cyc(0, 8'h28, 8'h20, 0, 8'h08, 1, 0, 3, 0);
        cyc(0, 8'h28, 8'h28, 0, 8'h08, 1, 0, 3, 0);
        cyc(0, 8'h20, 8'h20, 0, 8'h20, 0, 1, 3, 0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 5, 0);

        // queue 6 three-beat packet with a three-cycle stall after beat 1
        cyc(0, 8'h40, 8'h00, 0, 8'h40, 0, 0, 5, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h40, 8'h00, 1, 8'h00, 1, 0, 6, 0);
        cyc(0, 8'h40, 8'h00, 0, 8'h40, 1, 0, 6, 0);
        cyc(0, 8'h40, 8'h40, 0, 8'h40, 1, 0, 6, 0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 6, 0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 6, 0);

        // queue 2 runs 16 beats without eop (stalls inside must not count)
        cyc(0, 8'h04, 8'h00, 0, 8'h04, 0, 0, 6, 0);
        for (int i = 2; i <= 7; i++) cyc(0, 8'h04, 8'h00, 0, 8'h04, 1, 0, 2, 0);
        for (int i = 0; i < 2; i++)  cyc(0, 8'h04, 8'h00, 1, 8'h00, 1, 0, 2, 0);
        for (int i = 8; i <= 16; i++) cyc(0, 8'h04, 8'h00, 0, 8'h04, 1, 0, 2, 0);
        // forced release: ptr moved to 3, so queue 3 beats queues 0 and 2
        cyc(0, 8'h0D, 8'hFF, 0, 8'h08, 0, 0, 2, 1);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 3, 1);

        // owner 1 goes empty mid-packet: lock persists, queue 4 is ignored
        cyc(0, 8'h02, 8'h00, 0, 8'h02, 0, 0, 3, 1);
        for (int i = 0; i < 100; i++) cyc(0, 8'h10, 8'h00, 0, 8'h00, 1, 0, 1, 1);
        cyc(0, 8'h02, 8'h02, 0, 8'h02, 1, 0, 1, 1);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 1);

        // clr during a queue 5 lock: lock dropped, no pkt_done, restart at queue 0
        cyc(0, 8'h21, 8'h00, 0, 8'h20, 0, 0, 1, 1);
        cyc(0, 8'h21, 8'h00, 0, 8'h20, 1, 0, 5, 1);
        cyc(1, 8'h21, 8'h00, 0, 8'h00, 1, 0, 5, 1);
        cyc(0, 8'h21, 8'hFF, 0, 8'h01, 0, 0, 0, 0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL drain: got %0d left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
